rename_regfile: RTL and testbench

- Parametrised register alias table merged with the architectural register file for the out-of-order core; sits between decode/dispatch and the ROB commit port.
- Dispatch renames rd to a ROB index. Each source read returns committed data, a ready flag and the producing ROB index.
- Commit writes architectural data over COMMIT_WIDTH ports. Busy is cleared only when the committing ROB index matches the current mapping.
- A flush restores every mapping to the architectural state.

---
 rtl/rename_regfile.sv | 107 ++++++++++
 tb/tb_rename_regfile.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
// Register alias table merged with the architectural register file.
// Optional macro RENAME_REGFILE_COMMIT_BYPASS_EN forwards same-cycle commits to reads.
module rename_regfile #(
  parameter int NUM_REGS      = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int COMMIT_WIDTH  = 2,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  dis_valid,
  input  logic [AW-1:0]                         dis_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0]              dis_rob_idx,
  input  logic [NUM_READ*AW-1:0]                rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]        rd_data,
  output logic [NUM_READ-1:0]                   rd_ready,
  output logic [NUM_READ*ROB_IDX_WIDTH-1:0]     rd_rob_idx,
  input  logic [COMMIT_WIDTH-1:0]               cmt_valid,
  input  logic [COMMIT_WIDTH*AW-1:0]            cmt_rd_addr,
  input  logic [COMMIT_WIDTH*ROB_IDX_WIDTH-1:0] cmt_rob_idx,
  input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]    cmt_data,
  output logic [AW:0]                           busy_count
);

  logic [DATA_WIDTH-1:0]    data_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    data_d [NUM_REGS];
  logic [ROB_IDX_WIDTH-1:0] tag_q  [NUM_REGS];
  logic [ROB_IDX_WIDTH-1:0] tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q;
  logic [NUM_REGS-1:0]      busy_d;
  logic [AW:0]              cnt_d;
  logic [AW-1:0]            ca;
  logic [AW-1:0]            ra;

  // Ascending port order lets the youngest commit win the data write.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    ca     = '0;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      ca = cmt_rd_addr[c*AW +: AW];
      if (cmt_valid[c] && ca != '0) begin
        data_d[ca] = cmt_data[c*DATA_WIDTH +: DATA_WIDTH];
        if (busy_q[ca] &&
            tag_q[ca] == cmt_rob_idx[c*ROB_IDX_WIDTH +: ROB_IDX_WIDTH])
          busy_d[ca] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (dis_valid && dis_rd_addr != '0) begin
      busy_d[dis_rd_addr] = 1'b1;
      tag_d[dis_rd_addr]  = dis_rob_idx;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_count <= cnt_d;
    end
  end

  always_comb begin
    rd_data    = '0;
    rd_ready   = '0;
    rd_rob_idx = '0;
    ra         = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      ra = rd_addr[k*AW +: AW];
      rd_data[k*DATA_WIDTH +: DATA_WIDTH]          = data_q[ra];
      rd_ready[k]                                  = ~busy_q[ra];
      rd_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = tag_q[ra];
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (cmt_valid[c] && ra != '0 && busy_q[ra] &&
            cmt_rd_addr[c*AW +: AW] == ra &&
            cmt_rob_idx[c*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag_q[ra]) begin
          rd_ready[k] = 1'b1;
          rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
            cmt_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed plan plus random traffic
// checked against a per-register reference model.
module tb_rename_regfile;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TW = 5;

  logic clk = 0;
  logic rst, flush, dis_valid;
  logic [AW-1:0] dis_rd_addr;
  logic [TW-1:0] dis_rob_idx;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0] rd_ready;
  logic [2*TW-1:0] rd_rob_idx;
  logic [1:0] cmt_valid;
  logic [2*AW-1:0] cmt_rd_addr;
  logic [2*TW-1:0] cmt_rob_idx;
  logic [2*DW-1:0] cmt_data;
  logic [AW:0] busy_count;

  rename_regfile dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dis_valid(dis_valid), .dis_rd_addr(dis_rd_addr),
    .dis_rob_idx(dis_rob_idx), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ready(rd_ready),
    .rd_rob_idx(rd_rob_idx), .cmt_valid(cmt_valid),
    .cmt_rd_addr(cmt_rd_addr), .cmt_rob_idx(cmt_rob_idx),
    .cmt_data(cmt_data), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*DW-1:0] d;
    logic [1:0]      r;
    logic [2*TW-1:0] t;
    logic [AW:0]     cnt;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [TW-1:0] rob;
  } fl_t;

  exp_t expq[$];
  exp_t me;
  fl_t  inflight[$];
  logic chk_v = 0;
  int   nchk = 0;
  int   nfail = 0;

  logic [DW-1:0] m_data [32];
  logic [TW-1:0] m_tag  [32];
  logic          m_busy [32];

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_v) begin
      if (expq.size() == 0) begin
        cmp("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        me = expq.pop_front();
        cmp("sb_data", 64'(rd_data), 64'(me.d));
        cmp("sb_ready", 64'(rd_ready), 64'(me.r));
        for (int k = 0; k < 2; k++)
          if (me.r[k] == 1'b0)
            cmp("sb_rob_idx", 64'(rd_rob_idx[k*TW +: TW]),
                64'(me.t[k*TW +: TW]));
        cmp("sb_busy_count", 64'(busy_count), 64'(me.cnt));
      end
    end
  end

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_data[r] = '0; m_tag[r] = '0; m_busy[r] = 0;
    end
  endtask

  function automatic int nbusy();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // Expected outputs for the current inputs, then advance the model one edge.
  task automatic step();
    exp_t e;
    int   a, ca;
    logic clr [32];
    e.cnt = (AW+1)'(nbusy());
    for (int k = 0; k < 2; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      e.d[k*DW +: DW] = m_data[a];
      e.r[k] = !m_busy[a];
      e.t[k*TW +: TW] = m_tag[a];
      if (a == 0) begin
        e.d[k*DW +: DW] = '0; e.r[k] = 1; e.t[k*TW +: TW] = '0;
      end
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
      for (int c = 0; c < 2; c++)
        if (cmt_valid[c] && a != 0 && m_busy[a] &&
            int'(cmt_rd_addr[c*AW +: AW]) == a &&
            cmt_rob_idx[c*TW +: TW] == m_tag[a]) begin
          e.r[k] = 1; e.d[k*DW +: DW] = cmt_data[c*DW +: DW];
        end
`endif
    end
    expq.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      for (int r = 0; r < 32; r++) clr[r] = 0;
      for (int c = 0; c < 2; c++) begin
        ca = int'(cmt_rd_addr[c*AW +: AW]);
        if (cmt_valid[c] && ca != 0) begin
          m_data[ca] = cmt_data[c*DW +: DW];
          if (m_busy[ca] && m_tag[ca] == cmt_rob_idx[c*TW +: TW]) clr[ca] = 1;
        end
      end
      for (int r = 0; r < 32; r++) if (clr[r]) m_busy[r] = 0;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
      end else if (dis_valid && dis_rd_addr != 0) begin
        m_busy[dis_rd_addr] = 1;
        m_tag[dis_rd_addr]  = dis_rob_idx;
      end
    end
    chk_v = 1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    chk_v = 0;
    #1;
  endtask

  task automatic idle();
    flush = 0; dis_valid = 0; dis_rd_addr = '0; dis_rob_idx = '0;
    cmt_valid = '0; cmt_rd_addr = '0; cmt_rob_idx = '0; cmt_data = '0;
  endtask

  task automatic dis(int rd, int rob);
    dis_valid = 1; dis_rd_addr = AW'(rd); dis_rob_idx = TW'(rob);
  endtask

  task automatic cmt(int c, int rd, int rob, logic [DW-1:0] d);
    cmt_valid[c] = 1;
    cmt_rd_addr[c*AW +: AW] = AW'(rd);
    cmt_rob_idx[c*TW +: TW] = TW'(rob);
    cmt_data[c*DW +: DW] = d;
  endtask

  task automatic rd(int a0, int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic dchk(string nm, int k, logic er, logic [DW-1:0] ed, int et);
    cmp({nm, "_ready"}, 64'(rd_ready[k]), 64'(er));
    cmp({nm, "_data"}, 64'(rd_data[k*DW +: DW]), 64'(ed));
    if (!er) cmp({nm, "_rob"}, 64'(rd_rob_idx[k*TW +: TW]), 64'(et));
  endtask

  function automatic logic [TW-1:0] free_tag();
    logic [TW-1:0] t;
    bit hit;
    do begin
      t = TW'($urandom);
      hit = 0;
      foreach (inflight[i]) if (inflight[i].rob == t) hit = 1;
    end while (hit);
    return t;
  endfunction

  initial begin
    fl_t f;
    rst = 1; idle(); rd_addr = '0; model_reset();
    repeat (2) @(posedge clk);
    #1; rst = 0;

    idle(); rd(5, 0); step();
    dchk("reset_x5", 0, 1, 0, 0); dchk("reset_x0", 1, 1, 0, 0);
    cmp("reset_busy_count", 64'(busy_count), 0);
    tick();

    idle(); dis(3, 7); step(); tick();
    idle(); rd(3, 0); step(); dchk("x3_busy", 0, 0, 0, 7); tick();
    idle(); cmt(0, 3, 7, 32'hDEADBEEF); step(); tick();
    idle(); rd(3, 0); step();
    dchk("x3_commit", 0, 1, 32'hDEADBEEF, 0);
    cmp("x3_busy_count", 64'(busy_count), 0);
    tick();

    idle(); dis(4, 2); step(); tick();
    idle(); dis(4, 9); step(); tick();
    idle(); cmt(0, 4, 2, 32'h11); step(); tick();
    idle(); rd(4, 4); step(); dchk("x4_stale", 0, 0, 32'h11, 9); tick();
    idle(); cmt(1, 4, 9, 32'h22); step(); tick();
    idle(); rd(4, 0); step(); dchk("x4_final", 0, 1, 32'h22, 0); tick();

    idle(); dis(6, 10); step(); tick();
    idle(); cmt(0, 6, 3, 32'hA); cmt(1, 6, 10, 32'hB); dis(6, 12);
    step(); tick();
    idle(); rd(6, 6); step(); dchk("x6_same_cycle", 1, 0, 32'hB, 12); tick();

    idle(); dis(1, 1); cmt(0, 6, 12, 32'hC); step(); tick();
    idle(); dis(2, 2); step(); tick();
    idle(); dis(7, 13); step(); tick();
    idle(); rd(1, 7); step();
    cmp("flush_pre_count", 64'(busy_count), 3);
    tick();
    idle(); flush = 1; cmt(0, 7, 13, 32'h55); dis(9, 20); step(); tick();
    idle(); rd(7, 9); step();
    dchk("flush_x7", 0, 1, 32'h55, 0); dchk("flush_x9", 1, 1, 0, 0);
    cmp("flush_busy_count", 64'(busy_count), 0);
    tick();
    idle(); dis(0, 5); step(); tick();
    idle(); rd(0, 0); step(); dchk("x0_dispatch", 0, 1, 0, 0); tick();

    idle(); dis(8, 4); step(); tick();
    idle(); cmt(0, 8, 4, 32'h99); rd(8, 0); step();
`ifdef RENAME_REGFILE_COMMIT_BYPASS_EN
    dchk("bypass_same", 0, 1, 32'h99, 4);
`else
    dchk("nobypass_same", 0, 0, 32'h0, 4);
`endif
    tick();
    idle(); rd(8, 0); step(); dchk("bypass_next", 0, 1, 32'h99, 0); tick();

    idle(); rst = 1; step(); tick(); rst = 0;
    inflight.delete();

    for (int n = 0; n < 3000; n++) begin
      idle();
      rd_addr = 2*AW'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        rst = 1; dis(int'($urandom_range(0, 31)), 3);
        step(); tick(); rst = 0;
        inflight.delete();
        continue;
      end
      flush = ($urandom_range(0, 99) < 5);
      for (int c = 0; c < 2; c++) begin
        if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
          f = inflight.pop_front();
          cmt(c, int'(f.rd), int'(f.rob), $urandom);
        end else if ($urandom_range(0, 5) == 0) begin
          cmt(c, int'($urandom_range(0, 31)), int'(free_tag()), $urandom);
        end
      end
      if (inflight.size() < 20 && $urandom_range(0, 1) == 1) begin
        f.rd = AW'($urandom); f.rob = free_tag();
        dis(int'(f.rd), int'(f.rob));
        if (!flush && f.rd != 0) inflight.push_back(f);
      end
      if (flush) inflight.delete();
      step(); tick();
    end

    idle(); tick(); tick();
    cmp("queue_drain", 64'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
